ft245r_tx: RTL and testbench
============================

Name: ft245r_tx

Overview:
- Host-bound half of the FT245R USB FIFO link: the write-side transmitter complementing the existing read-side receiver.
- Accepts bytes from internal logic over a valid/ready handshake and buffers them in a small FIFO.
- Drains the FIFO to the FTDI chip with properly timed WR strobes, gated by TXE#.
- Drives data and output-enable to top-level tristate logic, which shares usb_bus with the receiver.

Parameters:
- DEPTH_LOG2, 3, log2 of the byte FIFO depth (depth 8).
- SETUP_CYC, 1, clk cycles data is driven with WR low before the strobe; range 1..15.
- WR_CYC, 3, clk cycles WR is held high (60 ns at 50 MHz, FT245R min 50 ns); range 1..15.
- HOLD_CYC, 1, clk cycles data stays driven after the WR falling edge; range 1..15.
- RECOVER_CYC, 3, idle cycles before TXE# is re-evaluated; range 3..15.

Ports:
- clk  in  1  system clock, 50 MHz.
- areset_n  in  1  asynchronous active-low reset.
- in_data  in  8  byte to send.
- in_valid  in  1  in_data valid.
- in_ready  out  1  FIFO can accept a byte; a transfer occurs when in_valid && in_ready on a clk rising edge.
- usb_txe_  in  1  FTDI TXE#, asynchronous; low means the chip can accept a byte.
- bus_busy  in  1  receiver currently owns usb_bus; no new write may start.
- usb_dout  out  8  data for usb_bus.
- usb_oe  out  1  top level drives usb_dout onto usb_bus when high.
- usb_wr  out  1  FTDI WR strobe; data is latched on its falling edge.
- tx_busy  out  1  high in any state other than IDLE.
- fifo_level  out  DEPTH_LOG2+1  bytes currently buffered.

Behaviour:
- Reset is asynchronous and active-low. While areset_n is low:
  - usb_wr=0, usb_oe=0, usb_dout=0, tx_busy=0, fifo_level=0, in_ready=0.
  - TXE# synchroniser flops reset to 1 (not ready).
  - FSM goes to IDLE.
- in_ready rises on the first clk edge after reset release.
- TXE# passes through a 2-flop synchroniser; txe_s is its output.
- FIFO:
  - in_ready = !full, registered.
  - A push while full is impossible because ready is low.
  - Push and pop in the same cycle when not full and not empty: level unchanged.
  - Push into an empty FIFO: the byte is visible to the FSM on the next cycle.
  - Pointers wrap modulo depth.
  - Level is exact from 0 to 2^DEPTH_LOG2.
- FSM states: IDLE, SETUP, STROBE, HOLD, RECOVER. One 4-bit down-counter cnt serves all timed states.
  - IDLE:
    - If !empty && !txe_s && !bus_busy, register the FIFO head into usb_dout, set usb_oe=1, cnt=SETUP_CYC-1, and go to SETUP.
    - Otherwise stay in IDLE.
    - bus_busy is only sampled in IDLE. Once SETUP is entered the write completes regardless of bus_busy.
  - SETUP: usb_wr=0, data driven. When cnt==0: usb_wr=1, cnt=WR_CYC-1, go to STROBE.
  - STROBE: usb_wr=1. When cnt==0: usb_wr=0 (falling edge latches the byte), pop the FIFO in the same cycle, cnt=HOLD_CYC-1, go to HOLD.
  - HOLD: data and oe stay asserted. When cnt==0: usb_oe=0, cnt=RECOVER_CYC-1, go to RECOVER.
  - RECOVER: oe=0, wr=0. When cnt==0, go to IDLE. The RECOVER_CYC>=3 minimum exists so that a stale TXE# low, still in the synchroniser, is never used to start a new write.
- Timing:
  - usb_wr high width is exactly WR_CYC cycles.
  - Cycles per byte = 1 (IDLE decision) + SETUP_CYC + WR_CYC + HOLD_CYC + RECOVER_CYC. Defaults give 9 cycles per byte.
  - Latency from an accepted push (empty FIFO, TXE# low and already synchronised) to usb_wr rising is 1 + 1 + SETUP_CYC cycles (3 with defaults).
- TXE# going high mid-write does not abort the write; the current byte completes.
- Reset mid-write:
  - Outputs drop immediately.
  - An asynchronous WR fall during STROBE may latch the in-flight byte at the FTDI. That byte has not been popped, but it is lost anyway because reset clears the FIFO.
  - This behaviour is accepted and documented.

Decomposition:
- ft245r_pkg holds:
  - state enum (IDLE, SETUP, STROBE, HOLD, RECOVER);
  - default timing constants;
  - CNT_W=4.
- The receiver is to use the same package.
- One sub-module: byte_fifo, a synchronous FIFO with DEPTH_LOG2 parameter, push/pop/full/empty/level, async active-low reset.
- Synchroniser and FSM are inline in ft245r_tx.

Test Plan:
- Reset, then hold TXE# low and push 0xA5 once. Required: usb_wr rises 3 cycles after the push and stays high exactly 3 cycles; usb_dout=0xA5 with oe=1 from SETUP through HOLD; fifo_level returns 0 at the WR fall.
- TXE# high, push 8 bytes 0x00..0x07. Required: in_ready=0 after the 8th push, fifo_level=8, no WR activity. Then drop TXE#. Required: 8 strobes in order 0x00..0x07, 9 cycles apart.
- TXE# toggles high for 10 cycles after each WR fall, modelling the FTDI. Required: no strobe starts while the synchronised TXE# is high, and no byte is lost or duplicated over 32 bytes.
- bus_busy high with the FIFO non-empty. Required: FSM stays in IDLE. Assert bus_busy during STROBE. Required: the write completes normally.
- Simultaneous push and pop at level 4. Required: level stays 4 and data order is preserved.
- Assert areset_n low mid-STROBE. Required: same-cycle wr=0, oe=0, level=0; after release, in_ready=1 on the next edge and no strobe occurs with the FIFO empty.

Source files
------------

// File: rtl/ft245r_pkg.sv
// Definitions shared by the FT245R USB FIFO link transmitter and receiver.
package ft245r_pkg;

    localparam int unsigned CNT_W           = 4;
    localparam int unsigned DEPTH_LOG2_DEF  = 3;
    localparam int unsigned SETUP_CYC_DEF   = 1;
    localparam int unsigned WR_CYC_DEF      = 3;
    localparam int unsigned HOLD_CYC_DEF    = 1;
    localparam int unsigned RECOVER_CYC_DEF = 3;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_STROBE  = 3'd2,
        ST_HOLD    = 3'd3,
        ST_RECOVER = 3'd4
    } tx_state_e;

    // Down-counter reload value for a phase lasting cyc cycles.
    function automatic logic [CNT_W-1:0] cnt_load(input int unsigned cyc);
        return CNT_W'(cyc - 1);
    endfunction

endpackage

// File: rtl/byte_fifo.sv
// Synchronous byte FIFO with exact level and a registered head/empty view.
module byte_fifo #(
    parameter int unsigned DEPTH_LOG2 = 3
) (
    input  logic                  clk,
    input  logic                  areset_n,
    input  logic [7:0]            push_data,
    input  logic                  push,
    input  logic                  pop,
    output logic [7:0]            head,
    output logic                  empty,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   level
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned LVL_W = DEPTH_LOG2 + 1;
    localparam int unsigned PTR_W = DEPTH_LOG2;

    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok_c;
    logic             pop_ok_c;
    logic [LVL_W-1:0] level_next_c;

    always_comb begin
        push_ok_c    = push && !full;
        pop_ok_c     = pop && (level != '0);
        level_next_c = level;
        case ({push_ok_c, pop_ok_c})
            2'b10:   level_next_c = level + LVL_W'(1);
            2'b01:   level_next_c = level - LVL_W'(1);
            default: level_next_c = level;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push_ok_c) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // full resets high so nothing is accepted before the first clock after reset.
    // head/empty trail the pointers by one cycle: a freshly pushed byte is
    // presented on the cycle after the push.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            full   <= 1'b1;
            empty  <= 1'b1;
            head   <= '0;
        end else begin
            if (push_ok_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok_c) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            level <= level_next_c;
            full  <= (level_next_c == LVL_W'(DEPTH));
            empty <= (level == '0);
            head  <= mem[rd_ptr];
        end
    end

endmodule

// File: rtl/ft245r_tx.sv
// FT245R write-side transmitter: buffers bytes and drives timed WR strobes gated by TXE#.
module ft245r_tx
    import ft245r_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2  = DEPTH_LOG2_DEF,
    parameter int unsigned SETUP_CYC   = SETUP_CYC_DEF,
    parameter int unsigned WR_CYC      = WR_CYC_DEF,
    parameter int unsigned HOLD_CYC    = HOLD_CYC_DEF,
    parameter int unsigned RECOVER_CYC = RECOVER_CYC_DEF
) (
    input  logic                  clk,
    input  logic                  areset_n,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  usb_txe_,
    input  logic                  bus_busy,
    output logic [7:0]            usb_dout,
    output logic                  usb_oe,
    output logic                  usb_wr,
    output logic                  tx_busy,
    output logic [DEPTH_LOG2:0]   fifo_level
);

    logic             fifo_full;
    logic             fifo_empty;
    logic [7:0]       fifo_head;
    logic             pop_c;
    logic             txe_meta;
    logic             txe_s;
    tx_state_e        state;
    logic [CNT_W-1:0] cnt;

    assign in_ready = !fifo_full;
    assign pop_c    = (state == ST_STROBE) && (cnt == '0);

    byte_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk       (clk),
        .areset_n  (areset_n),
        .push_data (in_data),
        .push      (in_valid),
        .pop       (pop_c),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .level     (fifo_level)
    );

    // TXE# synchroniser; resets to "not ready".
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            txe_meta <= 1'b1;
            txe_s    <= 1'b1;
        end else begin
            txe_meta <= usb_txe_;
            txe_s    <= txe_meta;
        end
    end

    // Write sequencer; once SETUP is entered the byte always completes.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            usb_dout <= '0;
            usb_oe   <= 1'b0;
            usb_wr   <= 1'b0;
            tx_busy  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty && !txe_s && !bus_busy) begin
                        usb_dout <= fifo_head;
                        usb_oe   <= 1'b1;
                        tx_busy  <= 1'b1;
                        cnt      <= cnt_load(SETUP_CYC);
                        state    <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (cnt == '0) begin
                        usb_wr <= 1'b1;
                        cnt    <= cnt_load(WR_CYC);
                        state  <= ST_STROBE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_STROBE: begin
                    if (cnt == '0) begin
                        usb_wr <= 1'b0;
                        cnt    <= cnt_load(HOLD_CYC);
                        state  <= ST_HOLD;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_HOLD: begin
                    if (cnt == '0) begin
                        usb_oe <= 1'b0;
                        cnt    <= cnt_load(RECOVER_CYC);
                        state  <= ST_RECOVER;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_RECOVER: begin
                    // Long enough that a stale TXE# low in the synchroniser has flushed.
                    if (cnt == '0) begin
                        tx_busy <= 1'b0;
                        state   <= ST_IDLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    usb_oe  <= 1'b0;
                    usb_wr  <= 1'b0;
                    tx_busy <= 1'b0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ft245r_tx.sv
// Directed self-checking bench for ft245r_tx with default timing parameters.
module tb_ft245r_tx;

    localparam int unsigned WR_CYC = 3;

    logic       clk = 1'b0;
    logic       areset_n = 1'b1;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       usb_txe_;
    logic       bus_busy = 1'b0;
    logic [7:0] usb_dout;
    logic       usb_oe;
    logic       usb_wr;
    logic       tx_busy;
    logic [3:0] fifo_level;

    logic       txe_req = 1'b1;
    bit         txe_model = 1'b0;
    int         txe_hold = 0;
    int         cyc = 0;
    logic       prev_wr = 1'b0;
    logic [7:0] rx_q[$];
    int         rise_q[$];
    int         fall_q[$];

    int n_checks = 0;
    int n_fail = 0;

    assign usb_txe_ = txe_req | (txe_hold != 0);

    ft245r_tx dut (
        .clk        (clk),
        .areset_n   (areset_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .usb_txe_   (usb_txe_),
        .bus_busy   (bus_busy),
        .usb_dout   (usb_dout),
        .usb_oe     (usb_oe),
        .usb_wr     (usb_wr),
        .tx_busy    (tx_busy),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Strobe recorder plus FTDI model holding TXE# high for 10 cycles after each WR fall.
    always @(negedge clk) begin
        if (txe_hold > 0) txe_hold = txe_hold - 1;
        if (!prev_wr && usb_wr) rise_q.push_back(cyc);
        if (prev_wr && !usb_wr) begin
            rx_q.push_back(usb_dout);
            fall_q.push_back(cyc);
            if (txe_model) txe_hold = 10;
        end
        prev_wr = usb_wr;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        bit ok_now;
        bit done;
        done     = 1'b0;
        in_data  = b;
        in_valid = 1'b1;
        for (int n = 0; n < 400 && !done; n++) begin
            ok_now = in_ready;
            @(posedge clk);
            @(negedge clk);
            done = ok_now;
        end
        in_valid = 1'b0;
        check_eq("push_accept", 32'(done), 32'd1);
    endtask

    task automatic wait_rx(input int n, input int budget, input string tag);
        int k;
        k = 0;
        while (rx_q.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check_eq(tag, 32'(rx_q.size() >= n), 32'd1);
    endtask

    task automatic wait_wr(input string tag);
        int k;
        k = 0;
        while (!usb_wr && k < 200) begin
            @(negedge clk);
            k++;
        end
        check_eq(tag, 32'(usb_wr), 32'd1);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog no_finish_by_500us");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int b;
        int rb;

        // ---- reset ----
        txe_req = 1'b0;
        #2 areset_n = 1'b0;
        idle_cycles(3);
        check_eq("rst_in_ready", 32'(in_ready), 32'd0);
        check_eq("rst_wr", 32'(usb_wr), 32'd0);
        check_eq("rst_oe", 32'(usb_oe), 32'd0);
        check_eq("rst_dout", 32'(usb_dout), 32'd0);
        check_eq("rst_busy", 32'(tx_busy), 32'd0);
        check_eq("rst_level", 32'(fifo_level), 32'd0);
        areset_n = 1'b1;
        @(negedge clk);
        check_eq("in_ready_after_rst", 32'(in_ready), 32'd1);
        idle_cycles(3);

        // ---- single byte timing ----
        push_byte(8'hA5);
        @(negedge clk);
        check_eq("t1_e1_oe", 32'(usb_oe), 32'd0);
        check_eq("t1_e1_wr", 32'(usb_wr), 32'd0);
        @(negedge clk);
        check_eq("t1_setup_oe", 32'(usb_oe), 32'd1);
        check_eq("t1_setup_dout", 32'(usb_dout), 32'hA5);
        check_eq("t1_setup_wr", 32'(usb_wr), 32'd0);
        check_eq("t1_setup_busy", 32'(tx_busy), 32'd1);
        @(negedge clk);
        check_eq("t1_wr_rise_lat3", 32'(usb_wr), 32'd1);
        @(negedge clk);
        check_eq("t1_wr_high2", 32'(usb_wr), 32'd1);
        check_eq("t1_level_strobe", 32'(fifo_level), 32'd1);
        @(negedge clk);
        check_eq("t1_wr_high3", 32'(usb_wr), 32'd1);
        @(negedge clk);
        check_eq("t1_wr_fall", 32'(usb_wr), 32'd0);
        check_eq("t1_hold_oe", 32'(usb_oe), 32'd1);
        check_eq("t1_hold_dout", 32'(usb_dout), 32'hA5);
        check_eq("t1_level_fall", 32'(fifo_level), 32'd0);
        @(negedge clk);
        check_eq("t1_recover_oe", 32'(usb_oe), 32'd0);
        check_eq("t1_recover_busy", 32'(tx_busy), 32'd1);
        idle_cycles(3);
        check_eq("t1_idle_busy", 32'(tx_busy), 32'd0);

        // ---- fill with TXE# high, then drain ----
        txe_req = 1'b1;
        idle_cycles(4);
        b  = rx_q.size();
        rb = rise_q.size();
        for (int i = 0; i < 8; i++) push_byte(8'(i));
        check_eq("t2_in_ready_full", 32'(in_ready), 32'd0);
        check_eq("t2_level_full", 32'(fifo_level), 32'd8);
        check_eq("t2_no_strobe", 32'(rise_q.size()), 32'(rb));
        txe_req = 1'b0;
        wait_rx(b + 8, 200, "t2_drain_timeout");
        for (int i = 0; i < 8; i++) begin
            check_eq("t2_byte", 32'(rx_q[b+i]), 32'(i));
            check_eq("t2_wr_width", 32'(fall_q[b+i] - rise_q[rb+i]), 32'(WR_CYC));
            if (i > 0) check_eq("t2_spacing", 32'(rise_q[rb+i] - rise_q[rb+i-1]), 32'd9);
        end
        idle_cycles(6);

        // ---- FTDI-style TXE# toggling over 32 bytes ----
        txe_model = 1'b1;
        b  = rx_q.size();
        rb = rise_q.size();
        for (int i = 0; i < 32; i++) push_byte(8'(8'h20 + i));
        wait_rx(b + 32, 1500, "t3_drain_timeout");
        check_eq("t3_count", 32'(rx_q.size() - b), 32'd32);
        for (int i = 0; i < 32; i++) begin
            check_eq("t3_byte", 32'(rx_q[b+i]), 32'(8'h20 + i));
            if (i > 0) check_eq("t3_txe_gap", 32'(rise_q[rb+i] - fall_q[b+i-1]), 32'd14);
        end
        txe_model = 1'b0;
        idle_cycles(16);

        // ---- bus_busy gating ----
        b  = rx_q.size();
        rb = rise_q.size();
        bus_busy = 1'b1;
        push_byte(8'hB0);
        push_byte(8'hB1);
        idle_cycles(20);
        check_eq("t4_busy_idle", 32'(tx_busy), 32'd0);
        check_eq("t4_busy_no_strobe", 32'(rise_q.size()), 32'(rb));
        check_eq("t4_busy_level", 32'(fifo_level), 32'd2);
        bus_busy = 1'b0;
        wait_wr("t4_wr_timeout");
        bus_busy = 1'b1;
        wait_rx(b + 1, 50, "t4_complete_timeout");
        check_eq("t4_byte0", 32'(rx_q[b]), 32'hB0);
        idle_cycles(20);
        check_eq("t4_level_after", 32'(fifo_level), 32'd1);
        check_eq("t4_idle_again", 32'(tx_busy), 32'd0);
        check_eq("t4_one_strobe", 32'(rise_q.size()), 32'(rb + 1));
        bus_busy = 1'b0;
        wait_rx(b + 2, 50, "t4_second_timeout");
        check_eq("t4_byte1", 32'(rx_q[b+1]), 32'hB1);
        idle_cycles(10);

        // ---- simultaneous push and pop at level 4 ----
        txe_req = 1'b1;
        idle_cycles(4);
        b = rx_q.size();
        for (int i = 0; i < 4; i++) push_byte(8'(8'h40 + i));
        check_eq("t5_level4", 32'(fifo_level), 32'd4);
        txe_req = 1'b0;
        wait_wr("t5_wr_timeout");
        idle_cycles(2);
        check_eq("t5_ready_at_l4", 32'(in_ready), 32'd1);
        in_data  = 8'h44;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check_eq("t5_wr_fell", 32'(usb_wr), 32'd0);
        check_eq("t5_level_kept", 32'(fifo_level), 32'd4);
        wait_rx(b + 5, 200, "t5_drain_timeout");
        for (int i = 0; i < 5; i++) check_eq("t5_order", 32'(rx_q[b+i]), 32'(8'h40 + i));
        idle_cycles(10);

        // ---- reset in the middle of STROBE ----
        push_byte(8'h99);
        wait_wr("t6_wr_timeout");
        #2 areset_n = 1'b0;
        #1;
        check_eq("t6_rst_wr", 32'(usb_wr), 32'd0);
        check_eq("t6_rst_oe", 32'(usb_oe), 32'd0);
        check_eq("t6_rst_level", 32'(fifo_level), 32'd0);
        check_eq("t6_rst_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        areset_n = 1'b1;
        rb = rise_q.size();
        @(negedge clk);
        check_eq("t6_ready_after", 32'(in_ready), 32'd1);
        idle_cycles(20);
        check_eq("t6_no_strobe", 32'(rise_q.size()), 32'(rb));
        check_eq("t6_level_empty", 32'(fifo_level), 32'd0);
        check_eq("t6_idle", 32'(tx_busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
